// File: rtl/nanci_phase_sequencer_if.sv
// Sequencer control/status bundle: run requests in, phase strobes out.
// master drives start/stall/abort; slave (the sequencer) drives status.
interface nanci_phase_sequencer_if #(
  parameter int ADDR_WIDTH  = 3,
  parameter int ROUND_WIDTH = 4
);
  logic                   start;
  logic                   stall;
  logic                   abort;
  logic [2:0]             phase;
  logic                   load_en;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic                   sort_en;
  logic                   compute_en;
  logic [1:0]             dir_sel;
  logic [ROUND_WIDTH-1:0] round;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stall, abort,
    input  phase, load_en, load_addr, sort_en,
    input  compute_en, dir_sel, round, busy, done
  );

  modport slave (
    input  start, stall, abort,
    output phase, load_en, load_addr, sort_en,
    output compute_en, dir_sel, round, busy, done
  );
endinterface

// File: rtl/nanci_phase_sequencer.sv
// PE-array phase sequencer: IDLE->LOAD->(SORT->COMPUTE)xN->DONE.
// Ports: clk, rst (async active-low), seq (slave bundle of control/status).
module nanci_phase_sequencer #(
  parameter int ADDR_WIDTH     = 3,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int NUM_ROUNDS     = 2,
  parameter int ROUND_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  nanci_phase_sequencer_if.slave    seq
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SORT = 3'd2,
    S_COMP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SORT_LAST = CW'(SORT_CYCLES - 1);
  localparam logic [CW-1:0] COMP_LAST = CW'(COMPUTE_CYCLES - 1);
  localparam logic [ROUND_WIDTH-1:0] RND_LAST =
    ROUND_WIDTH'(NUM_ROUNDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ROUND_WIDTH-1:0] r_round;
  logic                   r_held;

  logic w_run;
  logic w_hold;
  logic w_sort_last;
  logic w_comp_last;
  logic w_rnd_last;

  assign w_run = (r_state == S_LOAD) ||
                 (r_state == S_SORT) ||
                 (r_state == S_COMP);
  assign w_hold      = seq.stall && w_run;
  assign w_sort_last = (r_cnt == SORT_LAST);
  assign w_comp_last = (r_cnt == COMP_LAST);
  assign w_rnd_last  = (r_round == RND_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (seq.abort) begin
      w_next = S_IDLE;
    end else if (!w_hold) begin
      unique case (r_state)
        S_IDLE: if (seq.start) w_next = S_LOAD;
        S_LOAD: if (r_addr == ADDR_LAST) w_next = S_SORT;
        S_SORT: if (w_sort_last) w_next = S_COMP;
        S_COMP: if (w_comp_last)
                  w_next = w_rnd_last ? S_DONE : S_SORT;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // r_held marks a frozen repeat cycle so the strobes can be
  // suppressed from registered state alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_round <= '0;
      r_held  <= 1'b0;
    end else if (seq.abort) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_round <= '0;
      r_held  <= 1'b0;
    end else if (w_hold) begin
      r_held  <= 1'b1;
    end else begin
      r_held  <= 1'b0;
      unique case (r_state)
        // all-ones address rolls to 0 as LOAD exits
        S_LOAD: r_addr <= r_addr + 1'b1;
        S_SORT: r_cnt <= w_sort_last ? '0 : r_cnt + 1'b1;
        S_COMP: begin
          if (w_comp_last) begin
            r_cnt <= '0;
            if (!w_rnd_last) r_round <= r_round + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_addr  <= '0;
          r_round <= '0;
        end
      endcase
    end
  end

  always_comb begin
    seq.phase      = r_state;
    seq.load_en    = 1'b0;
    seq.load_addr  = '0;
    seq.sort_en    = 1'b0;
    seq.compute_en = 1'b0;
    seq.dir_sel    = 2'd0;
    seq.round      = r_round;
    seq.busy       = 1'b0;
    seq.done       = 1'b0;
    unique case (1'b1)
      (r_state == S_LOAD): begin
        seq.busy      = 1'b1;
        seq.load_en   = !r_held;
        seq.load_addr = r_addr;
      end
      (r_state == S_SORT): begin
        seq.busy    = 1'b1;
        seq.sort_en = !r_held;
        // odd rounds swap left/right for up/down
        seq.dir_sel = {r_round[0], r_cnt[0]};
      end
      (r_state == S_COMP): begin
        seq.busy       = 1'b1;
        seq.compute_en = !r_held;
      end
      (r_state == S_DONE): begin
        seq.busy = 1'b1;
        seq.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nanci_phase_sequencer.sv
// Scoreboard bench for nanci_phase_sequencer (default and long-sort DUTs).
// Stimulus pushes per-cycle expectations; negedge monitors compare.
module tb_nanci_phase_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nanci_phase_sequencer_if #(.ADDR_WIDTH(3), .ROUND_WIDTH(4)) ia();
  nanci_phase_sequencer_if #(.ADDR_WIDTH(2), .ROUND_WIDTH(4)) ib();

  nanci_phase_sequencer #(
    .ADDR_WIDTH(3), .SORT_CYCLES(1), .COMPUTE_CYCLES(1),
    .NUM_ROUNDS(2), .ROUND_WIDTH(4)
  ) dut_a (.clk(clk), .rst(rst), .seq(ia.slave));

  nanci_phase_sequencer #(
    .ADDR_WIDTH(2), .SORT_CYCLES(3), .COMPUTE_CYCLES(2),
    .NUM_ROUNDS(2), .ROUND_WIDTH(4)
  ) dut_b (.clk(clk), .rst(rst), .seq(ib.slave));

  typedef struct packed {
    logic [2:0] ph;
    logic       le;
    logic [2:0] la;
    logic       se;
    logic       ce;
    logic [1:0] ds;
    logic [3:0] rd;
    logic       bz;
    logic       dn;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic exp_t ex(int ph, int la, int ds, int rd, bit en);
    exp_t e;
    e.ph = 3'(ph);
    e.le = (ph == 1) && en;
    e.la = 3'(la);
    e.se = (ph == 2) && en;
    e.ce = (ph == 3) && en;
    e.ds = 2'(ds);
    e.rd = 4'(rd);
    e.bz = (ph != 0);
    e.dn = (ph == 4);
    return e;
  endfunction

  function automatic exp_t got_a();
    exp_t g;
    g = {ia.phase, ia.load_en, ia.load_addr, ia.sort_en,
         ia.compute_en, ia.dir_sel, ia.round, ia.busy, ia.done};
    return g;
  endfunction

  function automatic exp_t got_b();
    exp_t g;
    g = {ib.phase, ib.load_en, 1'b0, ib.load_addr, ib.sort_en,
         ib.compute_en, ib.dir_sel, ib.round, ib.busy, ib.done};
    return g;
  endfunction

  always @(negedge clk) begin
    exp_t e, g;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = got_a();
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL dutA vec%0d t=%0t: got %h required %h",
                 n_vec, $time, g, e);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = got_b();
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL dutB vec%0d t=%0t: got %h required %h",
                 n_vec, $time, g, e);
      end
    end
  end

  task automatic chk(string nm, int got, int req);
    n_vec++;
    if (got != req) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic cyc_a(bit s, bit st, bit ab, exp_t e);
    @(posedge clk);
    #1;
    ia.start = s;
    ia.stall = st;
    ia.abort = ab;
    qa.push_back(e);
  endtask

  task automatic cyc_b(bit s, exp_t e);
    @(posedge clk);
    #1;
    ib.start = s;
    qb.push_back(e);
  endtask

  // start already sampled; LOAD through DONE of the default run
  task automatic run_a(bit s);
    for (int i = 0; i < 8; i++) cyc_a(s, 0, 0, ex(1, i, 0, 0, 1));
    cyc_a(s, 0, 0, ex(2, 0, 0, 0, 1));
    cyc_a(s, 0, 0, ex(3, 0, 0, 0, 1));
    cyc_a(s, 0, 0, ex(2, 0, 2, 1, 1));
    cyc_a(s, 0, 0, ex(3, 0, 0, 1, 1));
    cyc_a(s, 0, 0, ex(4, 0, 0, 1, 1));
  endtask

  exp_t IDL;

  initial begin
    IDL = ex(0, 0, 0, 0, 0);
    rst = 1'b0;
    ia.start = 0; ia.stall = 0; ia.abort = 0;
    ib.start = 0; ib.stall = 0; ib.abort = 0;

    // reset state, start ignored while in reset
    cyc_a(1, 0, 0, IDL);
    cyc_a(0, 0, 0, IDL);
    #1 rst = 1'b1;
    cyc_a(0, 0, 0, IDL);

    // basic run
    cyc_a(1, 0, 0, IDL);
    run_a(0);
    cyc_a(0, 0, 0, IDL);

    // start+stall+abort in IDLE: stays IDLE
    cyc_a(1, 1, 1, IDL);
    cyc_a(0, 0, 0, IDL);

    // stall in IDLE ignored; stall at addr 4 and in SORT r1
    cyc_a(1, 1, 0, IDL);
    for (int i = 0; i < 4; i++) cyc_a(0, 0, 0, ex(1, i, 0, 0, 1));
    cyc_a(0, 1, 0, ex(1, 4, 0, 0, 1));
    cyc_a(0, 1, 0, ex(1, 4, 0, 0, 0));
    cyc_a(0, 0, 0, ex(1, 4, 0, 0, 0));
    for (int i = 5; i < 8; i++) cyc_a(0, 0, 0, ex(1, i, 0, 0, 1));
    cyc_a(0, 0, 0, ex(2, 0, 0, 0, 1));
    cyc_a(0, 0, 0, ex(3, 0, 0, 0, 1));
    cyc_a(0, 1, 0, ex(2, 0, 2, 1, 1));
    cyc_a(0, 0, 0, ex(2, 0, 2, 1, 0));
    cyc_a(0, 0, 0, ex(3, 0, 0, 1, 1));
    cyc_a(0, 1, 0, ex(4, 0, 0, 1, 1));
    cyc_a(0, 0, 0, IDL);

    // abort in COMPUTE round 1, then a clean run
    cyc_a(1, 0, 0, IDL);
    for (int i = 0; i < 8; i++) cyc_a(0, 0, 0, ex(1, i, 0, 0, 1));
    cyc_a(0, 0, 0, ex(2, 0, 0, 0, 1));
    cyc_a(0, 0, 0, ex(3, 0, 0, 0, 1));
    cyc_a(0, 0, 0, ex(2, 0, 2, 1, 1));
    cyc_a(0, 0, 1, ex(3, 0, 0, 1, 1));
    cyc_a(1, 0, 0, IDL);
    run_a(0);
    cyc_a(0, 0, 0, IDL);

    // abort beats stall in LOAD
    cyc_a(1, 0, 0, IDL);
    cyc_a(0, 1, 1, ex(1, 0, 0, 0, 1));
    cyc_a(0, 0, 0, IDL);

    // async reset during SORT
    cyc_a(1, 0, 0, IDL);
    for (int i = 0; i < 8; i++) cyc_a(0, 0, 0, ex(1, i, 0, 0, 1));
    cyc_a(0, 0, 0, ex(2, 0, 0, 0, 1));
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_phase", int'(ia.phase), 0);
    chk("rst_async_sort_en", int'(ia.sort_en), 0);
    chk("rst_async_busy", int'(ia.busy), 0);
    cyc_a(1, 0, 0, IDL);
    #1 rst = 1'b1;

    // start held high: run, DONE, one IDLE, LOAD again
    run_a(1);
    cyc_a(1, 0, 0, IDL);
    cyc_a(0, 0, 1, ex(1, 0, 0, 0, 1));
    cyc_a(0, 0, 0, IDL);

    // long SORT/COMPUTE, 4-entry LOAD
    cyc_b(1, IDL);
    for (int i = 0; i < 4; i++) cyc_b(0, ex(1, i, 0, 0, 1));
    cyc_b(0, ex(2, 0, 0, 0, 1));
    cyc_b(0, ex(2, 0, 1, 0, 1));
    cyc_b(0, ex(2, 0, 0, 0, 1));
    cyc_b(0, ex(3, 0, 0, 0, 1));
    cyc_b(0, ex(3, 0, 0, 0, 1));
    cyc_b(0, ex(2, 0, 2, 1, 1));
    cyc_b(0, ex(2, 0, 3, 1, 1));
    cyc_b(0, ex(2, 0, 2, 1, 1));
    cyc_b(0, ex(3, 0, 0, 1, 1));
    cyc_b(0, ex(3, 0, 0, 1, 1));
    cyc_b(0, ex(4, 0, 0, 1, 1));
    cyc_b(0, IDL);

    @(negedge clk);
    #1;
    chk("sb_drain", qa.size() + qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
